// File: rtl/digit_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display: dwell, blanking gap, digit skipping, frame pulse.
// Optional BRIGHTNESS_EN adds a 4-bit bright input that trims the active part of each dwell.
module digit_scan_ctrl #(
  parameter int DWELL_STEP = 3125,
  parameter int GAP        = 64,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_mask,
`ifdef BRIGHTNESS_EN
  input  logic [3:0] bright,
`endif
  output logic [7:0] sel,
  output logic [2:0] idx,
  output logic       frame_start,
  output logic       blank
);

  localparam int DWELL = 16 * DWELL_STEP;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [2:0] low_idx;
  logic [2:0] adv_idx;
  logic       adv_wrap;
  logic       mask_any;
  logic       advance;
  logic       show_on;

  assign mask_any = |digit_mask;

  // Lowest enabled digit, used when leaving IDLE.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (digit_mask[i]) low_idx = 3'(i);
    end
  end

  // Next enabled digit searching circularly from idx+1; a single-bit mask lands back on idx.
  always_comb begin
    logic       found;
    logic [2:0] j;
    found   = 1'b0;
    adv_idx = idx;
    j       = idx;
    for (int k = 1; k <= 8; k++) begin
      j = idx + 3'(k);
      if (!found && digit_mask[j]) begin
        found   = 1'b1;
        adv_idx = j;
      end
    end
    adv_wrap = (adv_idx <= idx);
  end

  assign advance = ((state == ST_GAP) && (cnt == GAP_LAST)) ||
                   ((GAP == 0) && (state == ST_SHOW) && (cnt == DWELL_LAST));

`ifdef BRIGHTNESS_EN
  logic [3:0] bright_q;
  logic [3:0] bright_sel;
  // The first SHOW cycle uses the live input; later cycles use the copy captured then.
  assign bright_sel = ((state == ST_SHOW) && (cnt == '0)) ? bright : bright_q;
  assign show_on    = (32'(cnt) + 32'd1) < ((32'(bright_sel) + 32'd1) * 32'(DWELL_STEP));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bright_q <= 4'd0;
    end else if ((state == ST_SHOW) && (cnt == '0)) begin
      bright_q <= bright;
    end
  end
`else
  assign show_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel         <= 8'hFF;
      idx         <= 3'd0;
      frame_start <= 1'b0;
      blank       <= 1'b1;
    end else if (!en) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel         <= 8'hFF;
      idx         <= 3'd0;
      frame_start <= 1'b0;
      blank       <= 1'b1;
    end else if (advance) begin
      cnt <= '0;
      if (!mask_any) begin
        state       <= ST_IDLE;
        sel         <= 8'hFF;
        frame_start <= 1'b0;
        blank       <= 1'b1;
      end else begin
        state       <= ST_SHOW;
        idx         <= adv_idx;
        sel         <= ~(8'b1 << adv_idx);
        frame_start <= adv_wrap;
        blank       <= 1'b0;
      end
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (mask_any) begin
            state       <= ST_SHOW;
            idx         <= low_idx;
            sel         <= ~(8'b1 << low_idx);
            frame_start <= 1'b1;
            blank       <= 1'b0;
          end else begin
            sel   <= 8'hFF;
            blank <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            // GAP==0 is handled by advance, so this path always enters the gap.
            state <= ST_GAP;
            cnt   <= '0;
            sel   <= 8'hFF;
            blank <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            sel   <= show_on ? ~(8'b1 << idx) : 8'hFF;
            blank <= ~show_on;
          end
        end
        ST_GAP: begin
          cnt   <= cnt + 1'b1;
          sel   <= 8'hFF;
          blank <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          sel   <= 8'hFF;
          blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with DWELL_STEP=2 (dwell 32) and GAP=3.
module tb_digit_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] digit_mask;
  logic [3:0] bright;
  logic [7:0] sel;
  logic [2:0] idx;
  logic       frame_start;
  logic       blank;

  int checks;
  int errors;

  digit_scan_ctrl #(
    .DWELL_STEP(2),
    .GAP       (3),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
`ifdef BRIGHTNESS_EN
    .bright     (bright),
`endif
    .sel        (sel),
    .idx        (idx),
    .frame_start(frame_start),
    .blank      (blank)
  );

  // Clock and reset-level stimulus
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full digit: 32 dwell cycles then 3 gap cycles; ends on the first cycle of the next digit.
  task automatic run_digit(input int d, input logic first);
    logic [7:0] exp_sel;
    exp_sel = ~(8'b1 << d);
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("d%0d_c%0d_sel", d, c), sel, exp_sel);
      chk($sformatf("d%0d_c%0d_fs", d, c), {7'b0, frame_start}, {7'b0, first && (c == 0)});
      if (c == 0) begin
        chk($sformatf("d%0d_idx", d), {5'b0, idx}, 8'(d));
        chk($sformatf("d%0d_blank", d), {7'b0, blank}, 8'h00);
      end
      step();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("d%0d_gap%0d_sel", d, g), sel, 8'hFF);
      chk($sformatf("d%0d_gap%0d_blank", d, g), {7'b0, blank}, 8'h01);
      chk($sformatf("d%0d_gap%0d_fs", d, g), {7'b0, frame_start}, 8'h00);
      step();
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    en         = 1'b1;
    digit_mask = 8'hFF;
    bright     = 4'd15;

    // Reset held for two edges
    step();
    step();
    chk("rst_sel", sel, 8'hFF);
    chk("rst_idx", {5'b0, idx}, 8'h00);
    chk("rst_fs", {7'b0, frame_start}, 8'h00);
    chk("rst_blank", {7'b0, blank}, 8'h01);

    // Full frame over all eight digits
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 8; d++) run_digit(d, d == 0);
    chk("frame2_sel", sel, 8'hFE);
    chk("frame2_fs", {7'b0, frame_start}, 8'h01);

    // Mask 0b101 alternates digits 0 and 2
    digit_mask = 8'h05;
    run_digit(0, 1'b1);
    run_digit(2, 1'b0);
    run_digit(0, 1'b1);
    run_digit(2, 1'b0);

    // Mask cleared during digit 2: finish dwell and gap, then idle
    run_digit(0, 1'b1);
    digit_mask = 8'h00;
    run_digit(2, 1'b0);
    chk("idle_sel", sel, 8'hFF);
    chk("idle_idx", {5'b0, idx}, 8'h02);
    chk("idle_blank", {7'b0, blank}, 8'h01);
    chk("idle_fs", {7'b0, frame_start}, 8'h00);
    step();
    chk("idle2_sel", sel, 8'hFF);
    digit_mask = 8'h01;
    step();
    chk("restart_sel", sel, 8'hFE);
    chk("restart_fs", {7'b0, frame_start}, 8'h01);
    chk("restart_idx", {5'b0, idx}, 8'h00);

    // Disable at cycle 10 of digit 3
    digit_mask = 8'h08;
    run_digit(0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("d3_pre_c%0d_sel", c), sel, 8'hF7);
      chk($sformatf("d3_pre_c%0d_fs", c), {7'b0, frame_start}, 8'h00);
      step();
    end
    en = 1'b0;
    step();
    chk("dis_sel", sel, 8'hFF);
    chk("dis_idx", {5'b0, idx}, 8'h00);
    chk("dis_blank", {7'b0, blank}, 8'h01);
    chk("dis_fs", {7'b0, frame_start}, 8'h00);
    digit_mask = 8'h09;
    en = 1'b1;
    step();
    run_digit(0, 1'b1);
    run_digit(3, 1'b0);
    chk("wrap_sel", sel, 8'hFE);
    chk("wrap_fs", {7'b0, frame_start}, 8'h01);

    // Reset mid-dwell
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("mrst_sel", sel, 8'hFF);
    chk("mrst_idx", {5'b0, idx}, 8'h00);
    chk("mrst_fs", {7'b0, frame_start}, 8'h00);
    chk("mrst_blank", {7'b0, blank}, 8'h01);
    rst_n = 1'b1;
    step();
    chk("mrst_resume_sel", sel, 8'hFE);
    chk("mrst_resume_fs", {7'b0, frame_start}, 8'h01);

`ifdef BRIGHTNESS_EN
    // Brightness 3 on single digit: 8 lit, 24 dark, 3 gap
    digit_mask = 8'h01;
    bright     = 4'd3;
    en         = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 35; c++) begin
        chk($sformatf("br_f%0d_c%0d_sel", f, c), sel, (c < 8) ? 8'hFE : 8'hFF);
        chk($sformatf("br_f%0d_c%0d_blank", f, c), {7'b0, blank}, (c < 8) ? 8'h00 : 8'h01);
        chk($sformatf("br_f%0d_c%0d_fs", f, c), {7'b0, frame_start}, (c == 0) ? 8'h01 : 8'h00);
        step();
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
